// File: rtl/memory_stage_pkg.sv
// Shared MEM-stage definitions: FSM states, writeback source encodings and
// the bubble values loaded into MEM/WB while an access is outstanding.
package memory_stage_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

    // regWrtSrc encodings, common to decode and writeback
    localparam logic [2:0] WB_SRC_ALU = 3'd0;
    localparam logic [2:0] WB_SRC_MEM = 3'd1;
    localparam logic [2:0] WB_SRC_SET = 3'd2;
    localparam logic [2:0] WB_SRC_PC  = 3'd3;

    localparam logic BUBBLE_REG_WRT = 1'b0;
    localparam logic BUBBLE_HALT    = 1'b0;

endpackage

// File: rtl/memory_stage_req_fsm.sv
// Data-memory request sequencer: IDLE/WAIT state, request latches, strobes,
// stall and the capture/bubble select for MEM/WB. Honours MEM_ALIGN_CHECK_EN.
module mem_req_fsm
    import memory_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en_i,
    input  logic        mem_wrt_i,
    input  logic [15:0] addr_i,
    input  logic [15:0] wdata_i,
    input  logic        mem_done_i,
    output logic [15:0] mem_addr_o,
    output logic [15:0] mem_wdata_o,
    output logic        mem_rd_o,
    output logic        mem_wr_o,
    output logic        stall_o,
    output logic        capture_o,
    output logic        load_rdata_o,
    output logic        clear_mdata_o,
    output logic        drop_wrt_o,
    output logic        flag_err_o
);

    mem_state_e  state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        wrt_q, wrt_d;
    logic        misalign;
    logic        stray_done;

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign   = addr_i[0];
    assign stray_done = mem_done_i;
`else
    assign misalign   = 1'b0;
    assign stray_done = 1'b0;
`endif

    // NOTE: every output and next-state gets a default first so no latch is inferred.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wrt_d         = wrt_q;
        mem_addr_o    = addr_q;
        mem_wdata_o   = wdata_q;
        mem_rd_o      = 1'b0;
        mem_wr_o      = 1'b0;
        stall_o       = 1'b0;
        capture_o     = 1'b0;
        load_rdata_o  = 1'b0;
        clear_mdata_o = 1'b0;
        drop_wrt_o    = 1'b0;
        flag_err_o    = 1'b0;

        unique case (state_q)
            IDLE: begin
                mem_addr_o  = addr_i;
                mem_wdata_o = wdata_i;
                if (mem_en_i && !misalign) begin
                    mem_rd_o = ~mem_wrt_i;
                    mem_wr_o = mem_wrt_i;
                    stall_o  = 1'b1;
                    addr_d   = addr_i;
                    wdata_d  = wdata_i;
                    wrt_d    = mem_wrt_i;
                    state_d  = WAIT;
                end else begin
                    capture_o     = 1'b1;
                    clear_mdata_o = 1'b1;
                    drop_wrt_o    = mem_en_i & misalign;
                    flag_err_o    = (mem_en_i & misalign) | stray_done;
                end
            end
            WAIT: begin
                if (mem_done_i) begin
                    capture_o    = 1'b1;
                    load_rdata_o = ~wrt_q;
                    state_d      = IDLE;
                end else begin
                    stall_o = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Reset silences the memory port and upstream stall in the reset cycle itself.
        if (rst) begin
            mem_rd_o = 1'b0;
            mem_wr_o = 1'b0;
            stall_o  = 1'b0;
        end
    end

    // NOTE: the request latches are plain flops, so they are reset along with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            wrt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wrt_q   <= wrt_d;
        end
    end

endmodule

// File: rtl/memory_stage.sv
// MEM stage of the 16-bit WISC core: data-memory handshake plus MEM/WB bank.
// Optional misaligned-access/stray-done checking under MEM_ALIGN_CHECK_EN.
module memory_stage
    import memory_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] aluOut,
    input  logic [15:0] reg2DataOut,
    input  logic        memEnOut,
    input  logic        memWrtOut,
    input  logic        regWrtOut,
    input  logic [2:0]  regWrtSrcOut,
    input  logic [2:0]  writeRegOut,
    input  logic [15:0] setVal,
    input  logic [15:0] nextPcOut,
    input  logic        haltOut,
    input  logic        err,
    output logic [15:0] memAddr,
    output logic [15:0] memWData,
    output logic        memRd,
    output logic        memWr,
    input  logic [15:0] memRData,
    input  logic        memDone,
    output logic        stall,
    output logic [15:0] wbAluOut,
    output logic [15:0] wbMemData,
    output logic [15:0] wbSetVal,
    output logic [15:0] wbNextPc,
    output logic        wbRegWrt,
    output logic [2:0]  wbRegWrtSrc,
    output logic [2:0]  wbWriteReg,
    output logic        wbHalt,
    output logic        wbErr
);

    logic capture, load_rdata, clear_mdata, drop_wrt, flag_err;

    mem_req_fsm u_req_fsm (
        .clk          (clk),
        .rst          (rst),
        .mem_en_i     (memEnOut),
        .mem_wrt_i    (memWrtOut),
        .addr_i       (aluOut),
        .wdata_i      (reg2DataOut),
        .mem_done_i   (memDone),
        .mem_addr_o   (memAddr),
        .mem_wdata_o  (memWData),
        .mem_rd_o     (memRd),
        .mem_wr_o     (memWr),
        .stall_o      (stall),
        .capture_o    (capture),
        .load_rdata_o (load_rdata),
        .clear_mdata_o(clear_mdata),
        .drop_wrt_o   (drop_wrt),
        .flag_err_o   (flag_err)
    );

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            wbAluOut    <= 16'h0000;
            wbMemData   <= 16'h0000;
            wbSetVal    <= 16'h0000;
            wbNextPc    <= 16'h0000;
            wbRegWrt    <= 1'b0;
            wbRegWrtSrc <= 3'd0;
            wbWriteReg  <= 3'd0;
            wbHalt      <= 1'b0;
            wbErr       <= 1'b0;
        end else begin
            if (capture) begin
                wbAluOut    <= aluOut;
                wbSetVal    <= setVal;
                wbNextPc    <= nextPcOut;
                wbRegWrt    <= regWrtOut & ~drop_wrt;
                wbRegWrtSrc <= regWrtSrcOut;
                wbWriteReg  <= writeRegOut;
                wbHalt      <= haltOut;
            end else begin
                wbRegWrt <= BUBBLE_REG_WRT;
                wbHalt   <= BUBBLE_HALT;
            end

            // Stores leave the previous load data in place.
            if (load_rdata)
                wbMemData <= memRData;
            else if (clear_mdata)
                wbMemData <= 16'h0000;

            if ((capture && err) || flag_err)
                wbErr <= 1'b1;
        end
    end

endmodule

// File: doc/memory_stage.md
# memory_stage

Pipeline MEM stage of the 16-bit WISC core, the consumer of the EX/MEM register bank. It takes the registered ALU result, store data and memory/writeback control from execute. It drives a variable-latency data-memory handshake and stalls upstream while an access is outstanding. It then presents the MEM/WB register bank (ALU result, load data, writeback control) to the writeback stage.

## Interface
Parameters:
- none (16-bit datapath, 3-bit register specifiers fixed)

Ports (name direction width meaning):
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- aluOut  in  16  EX result; data-memory address for loads/stores
- reg2DataOut  in  16  store data
- memEnOut / memWrtOut  in  1/1  access enable / write (1) vs read (0)
- regWrtOut / regWrtSrcOut / writeRegOut  in  1/3/3  writeback enable, source select, destination
- setVal / nextPcOut  in  16/16  pass-through values for SLT-type and JAL writeback
- haltOut / err  in  1/1  halt and upstream error
- memAddr / memWData  out  16/16  memory request address / write data
- memRd / memWr  out  1/1  one-cycle request strobes
- memRData  in  16  read data, valid with memDone
- memDone  in  1  access complete (≥1 cycle after strobe)
- stall  out  1  hold EX/MEM and all earlier stages this cycle
- wbAluOut / wbMemData / wbSetVal / wbNextPc  out  16 each  MEM/WB data registers
- wbRegWrt / wbRegWrtSrc / wbWriteReg  out  1/3/3  MEM/WB writeback control
- wbHalt / wbErr  out  1/1  registered halt / error (sticky until rst)

## Operation
- FSM states: IDLE, WAIT.
- IDLE, memEnOut=0: stall=0; MEM/WB registers capture inputs; wbMemData=0.
- IDLE, memEnOut=1: memRd=~memWrtOut, memWr=memWrtOut for this cycle only. memAddr/memWData are driven from the inputs and latched internally. stall=1; MEM/WB loads a bubble. Next state is WAIT.
- A bubble sets wbRegWrt=0 and wbHalt=0; the data registers hold their previous values.
- WAIT, memDone=0: stall=1; no strobes; memAddr/memWData driven from the latches; bubble into MEM/WB.
- WAIT, memDone=1: stall=0; MEM/WB captures the inputs, which upstream is still holding. wbMemData=memRData for reads and holds for writes. Next state is IDLE.
- memDone in IDLE is ignored with no state change. Under MEM_ALIGN_CHECK_EN it also sets wbErr.
- wbErr is set on any input err=1 accepted into MEM/WB and stays set until rst.
- haltOut=1 with memEnOut=1 completes the access first; wbHalt asserts only on the capture cycle.
- Widths: no arithmetic in this stage; all 16-bit values are passed bit-exact.

## Timing
- Non-memory instruction: 1-cycle latency; input at edge N is visible on wb* after edge N+1; no stall.
- Memory access: issue cycle plus k≥1 wait cycles. stall is high for 1+(k−1) cycles and low on the memDone cycle. The instruction reaches wb* on the edge ending the memDone cycle.
- Back-to-back accesses: a second access issues in the cycle immediately after the memDone cycle, with no gap cycle.
- rst (any state, including WAIT): next edge goes to IDLE. All wb* outputs, latches and wbErr return to 0. memRd=memWr=0 and stall=0 from the reset cycle onward. A late memDone after reset is ignored.
- stall is combinational from state, memEnOut and memDone. There is no combinational path from memRData to stall.

## Configuration
- MEM_ALIGN_CHECK_EN defined:
  - An access with aluOut[0]=1 is not issued: no strobe, no stall.
  - The instruction is captured immediately with wbRegWrt=0 and wbErr=1.
  - A memDone arriving in IDLE also sets wbErr.
- MEM_ALIGN_CHECK_EN undefined:
  - Odd addresses are issued unchanged.
  - A stray memDone is silently ignored.

## Structure
- Shared pipeline header/package holds:
  - FSM state localparams (IDLE=1'b0, WAIT=1'b1)
  - regWrtSrc encodings, shared with decode and writeback
  - the bubble-value constants
- MEM/WB registers are built from the existing dff cell arrays, using the same reset cell as EX/MEM.
- One natural sub-module: mem_req_fsm. It contains the state register, address/data latches, strobe and stall generation, and exports a capture/bubble select to the register bank.

## Test plan
- Non-memory op, aluOut=16'h1234, regWrt=1, writeReg=3 → next edge wbAluOut=16'h1234, wbRegWrt=1, wbWriteReg=3, stall never high.
- Load from addr 16'h0040, memDone after 3 cycles with memRData=16'hBEEF → memRd pulses 1 cycle, stall high 3 cycles, then wbMemData=16'hBEEF, wbRegWrt=1 exactly once.
- Store 16'hA5A5 to 16'h0010, then a load the cycle after memDone → memWr pulse with memWData=16'hA5A5; memRd asserts on the very next cycle; wbRegWrt=0 for the store.
- rst asserted during WAIT, memDone arrives 1 cycle after rst deasserts → all wb*=0, no strobe, state IDLE, done ignored.
- halt=1 on a load with 2-cycle memory → wbHalt rises only on the edge that captures the load data.
- With MEM_ALIGN_CHECK_EN, load from 16'h0041 → no memRd, stall=0, wbErr=1, wbRegWrt=0. Without the macro → memRd issued to 16'h0041.
